// File: rtl/norm_cdf_interp.sv
// rtl/norm_cdf_interp.sv - normal-CDF lookup with linear interpolation, symmetry and saturation
// Three-stage stream: accept/address, ROM capture, interpolate/output; one global stall.
module norm_cdf_interp #(
   parameter int XW        = 16,
   parameter int VW        = 16,
   parameter int ADDR_W    = 10,
   parameter int IDX_SHIFT = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XW-1:0]     in_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VW-1:0]     out_y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [VW-1:0]     rom_val1,
   input  logic [VW-1:0]     rom_val2,
   output logic [15:0]       sat_cnt
);

   localparam int PW = VW + IDX_SHIFT;
   localparam logic [XW:0]       SAT_MAG  = (XW+1)'(1) << (XW-1);
   localparam logic [ADDR_W-1:0] SAT_ADDR = ADDR_W'(1) << (XW-1-IDX_SHIFT);
   localparam logic [VW-1:0]     ONE      = VW'(1) << (VW-1);

   logic                 stall;
   logic [XW:0]          mag_d;
   logic                 sat_d;
   logic [ADDR_W-1:0]    addr_d;
   logic [VW-1:0]        diff_d;
   logic [PW-1:0]        prod_d;
   logic [VW-1:0]        ypos_d;
   logic [VW-1:0]        y_d;

   logic                 s0_valid_q, s0_sign_q, s0_sat_q;
   logic [IDX_SHIFT-1:0] s0_frac_q;
   logic [ADDR_W-1:0]    rom_addr_q;
   logic                 s1_valid_q, s1_sign_q, s1_sat_q;
   logic [IDX_SHIFT-1:0] s1_frac_q;
   logic [VW-1:0]        s1_v1_q, s1_v2_q;
   logic                 out_valid_q;
   logic [VW-1:0]        out_y_q;
   logic [15:0]          sat_cnt_q;

   always_comb begin
      stall  = out_valid_q && !out_ready;
      // 17-bit magnitude so that -8.0 (0x8000) becomes +8.0 and lands in saturation
      mag_d  = in_x[XW-1] ? -{in_x[XW-1], in_x} : {in_x[XW-1], in_x};
      sat_d  = (mag_d >= SAT_MAG);
      addr_d = sat_d ? SAT_ADDR : ADDR_W'(mag_d[XW-2:IDX_SHIFT]);
      diff_d = s1_v2_q - s1_v1_q;
      prod_d = PW'(diff_d) * PW'(s1_frac_q);
      ypos_d = s1_v1_q + VW'(prod_d >> IDX_SHIFT);
      if (s1_sat_q)
         y_d = s1_sign_q ? '0 : ONE;
      else
         y_d = s1_sign_q ? (ONE - ypos_d) : ypos_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_q  <= 1'b0;
         s0_sign_q   <= 1'b0;
         s0_sat_q    <= 1'b0;
         s0_frac_q   <= '0;
         rom_addr_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_sat_q    <= 1'b0;
         s1_frac_q   <= '0;
         s1_v1_q     <= '0;
         s1_v2_q     <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         sat_cnt_q   <= '0;
      end else if (!stall) begin
         s0_valid_q <= in_valid;
         if (in_valid) begin
            s0_sign_q  <= in_x[XW-1];
            s0_sat_q   <= sat_d;
            s0_frac_q  <= mag_d[IDX_SHIFT-1:0];
            rom_addr_q <= addr_d;
            if (sat_d)
               sat_cnt_q <= sat_cnt_q + 16'd1;
         end
         s1_valid_q <= s0_valid_q;
         if (s0_valid_q) begin
            s1_sign_q <= s0_sign_q;
            s1_sat_q  <= s0_sat_q;
            s1_frac_q <= s0_frac_q;
            s1_v1_q   <= rom_val1;
            s1_v2_q   <= rom_val2;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q)
            out_y_q <= y_d;
      end
   end

   assign in_ready  = !stall;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign rom_addr  = rom_addr_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_norm_cdf_interp.sv
// tb/tb_norm_cdf_interp.sv - randomized self-checking bench for norm_cdf_interp
// ROM is a synthetic monotone table pinned at the reference points; results go through a scoreboard.
module tb_norm_cdf_interp;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic [9:0]  rom_addr;
   logic [15:0] rom_val1;
   logic [15:0] rom_val2;
   logic [15:0] sat_cnt;

   int          rom [513];
   int          tests = 0;
   int          fails = 0;
   int          exp_sat = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   norm_cdf_interp dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .rom_addr  (rom_addr),
      .rom_val1  (rom_val1),
      .rom_val2  (rom_val2),
      .sat_cnt   (sat_cnt)
   );

   assign rom_val1 = (rom_addr <= 10'd512) ? 16'(rom[rom_addr]) : 16'h0;
   assign rom_val2 = (rom_addr >= 10'd512) ? 16'(rom[512]) : 16'(rom[rom_addr + 10'd1]);

   function automatic logic [15:0] ref_y(input logic [15:0] x);
      int xs, m, i, f, y;
      xs = $signed(x);
      m  = (xs < 0) ? -xs : xs;
      if (m >= 32768) return (xs < 0) ? 16'h0000 : 16'h8000;
      i = m / 64;
      f = m % 64;
      y = rom[i] + ((rom[i+1] - rom[i]) * f) / 64;
      return (xs < 0) ? 16'(32768 - y) : 16'(y);
   endfunction

   task automatic send_one(input logic [15:0] x, output logic [9:0] addr, output int lat,
                           output logic [15:0] y);
      @(negedge clk);
      in_valid = 1'b1; in_x = x; out_ready = 1'b1;
      @(posedge clk); #1;
      addr = rom_addr;
      in_valid = 1'b0;
      lat = 0; y = 16'hxxxx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (out_valid) begin lat = n; y = out_y; break; end
      end
   endtask

   task automatic cycle(input logic iv, input logic [15:0] x, input logic ordy,
                        output logic acc, output logic rdy, output logic ov, output logic [15:0] y);
      @(negedge clk);
      in_valid = iv; in_x = x; out_ready = ordy;
      #1;
      rdy = in_ready; acc = iv && in_ready; ov = out_valid; y = out_y;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp_sat = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests++; if (out_y !== 16'h0) begin fails++; $display("FAIL reset_out_y: got %h want 0000", out_y); end
      tests++; if (rom_addr !== 10'd0) begin fails++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
      tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
      rst = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_zero();
      logic [9:0] a; int lat; logic [15:0] y;
      send_one(16'h0000, a, lat, y);
      tests++; if (a !== 10'd0) begin fails++; $display("FAIL zero_addr: got %0d want 0", a); end
      tests++; if (lat != 3) begin fails++; $display("FAIL zero_latency: got %0d want 3", lat); end
      tests++; if (y !== 16'h4000) begin fails++; $display("FAIL zero_y: got %h want 4000", y); end
   endtask

   task automatic test_one_sigma();
      logic [9:0] a; int lat; logic [15:0] y;
      send_one(16'h1000, a, lat, y);
      tests++; if (a !== 10'd64) begin fails++; $display("FAIL sigma_pos_addr: got %0d want 64", a); end
      tests++; if (y !== 16'h6BB1) begin fails++; $display("FAIL sigma_pos_y: got %h want 6bb1", y); end
      send_one(16'hF000, a, lat, y);
      tests++; if (a !== 10'd64) begin fails++; $display("FAIL sigma_neg_addr: got %0d want 64", a); end
      tests++; if (y !== 16'h144F) begin fails++; $display("FAIL sigma_neg_y: got %h want 144f", y); end
   endtask

   task automatic test_interp();
      logic [9:0] a; int lat; logic [15:0] y; logic [15:0] x;
      send_one(16'h0020, a, lat, y);
      tests++; if (y !== 16'h4066) begin fails++; $display("FAIL interp_0020: got %h want 4066", y); end
      x = 16'($urandom_range(1, 32767));
      send_one(x, a, lat, y);
      tests++; if (y !== ref_y(x)) begin fails++; $display("FAIL interp_rand x=%h: got %h want %h", x, y, ref_y(x)); end
      x = 16'(-int'($urandom_range(1, 32767)));
      send_one(x, a, lat, y);
      tests++; if (y !== ref_y(x)) begin fails++; $display("FAIL interp_rand_neg x=%h: got %h want %h", x, y, ref_y(x)); end
   endtask

   task automatic test_saturation();
      logic [9:0] a; int lat; logic [15:0] y;
      send_one(16'h8000, a, lat, y);
      exp_sat++;
      tests++; if (a !== 10'd512) begin fails++; $display("FAIL sat_addr: got %0d want 512", a); end
      tests++; if (y !== 16'h0000) begin fails++; $display("FAIL sat_y: got %h want 0000", y); end
      tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL sat_cnt_inc: got %0d want %0d", sat_cnt, exp_sat); end
      send_one(16'h7FFF, a, lat, y);
      tests++; if (a !== 10'd511) begin fails++; $display("FAIL max_addr: got %0d want 511", a); end
      tests++; if (y !== ref_y(16'h7FFF)) begin fails++; $display("FAIL max_y: got %h want %h", y, ref_y(16'h7FFF)); end
      tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL max_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] xs [8];
      logic acc, rdy, ov, ordy; logic [15:0] y, held;
      int i = 0, got = 0;
      for (int k = 0; k < 8; k++) xs[k] = 16'($urandom);
      xs[2] = 16'h8000;
      held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         ordy = !(c >= 4 && c <= 6);
         cycle(i < 8, (i < 8) ? xs[i] : 16'h0, ordy, acc, rdy, ov, y);
         if (c == 4) held = y;
         if (c >= 4 && c <= 6) begin
            tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL b2b_stall_ready c=%0d: got %b want 0", c, rdy); end
            tests++; if (y !== held) begin fails++; $display("FAIL b2b_stall_hold c=%0d: got %h want %h", c, y, held); end
         end
         if (acc) begin
            if (xs[i] == 16'h8000) exp_sat++;
            exp_q.push_back(ref_y(xs[i])); i++;
         end
         if (ov && ordy) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_extra: got %h want none", y); end
            else begin
               if (y !== exp_q[0]) begin fails++; $display("FAIL b2b_data #%0d: got %h want %h", got, y, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            got++;
         end
      end
      tests++; if (got != 8 || i != 8) begin fails++; $display("FAIL b2b_count: got %0d/%0d want 8/8", got, i); end
      for (int c = 0; c < 5; c++) begin
         cycle(1'b0, 16'h0, 1'b1, acc, rdy, ov, y);
         tests++; if (ov !== 1'b0) begin fails++; $display("FAIL b2b_dup c=%0d: got %b want 0", c, ov); end
      end
      tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL b2b_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end
   endtask

   task automatic test_random();
      logic acc, rdy, ov, ordy, iv; logic [15:0] y, x;
      x = 16'($urandom);
      for (int c = 0; c < 420; c++) begin
         iv   = (c < 400) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0) || (c >= 400);
         cycle(iv, x, ordy, acc, rdy, ov, y);
         if (acc) begin
            if (x == 16'h8000) exp_sat++;
            exp_q.push_back(ref_y(x));
            x = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
         end
         if (ov && ordy) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL rand_extra c=%0d: got %h want none", c, y); end
            else begin
               if (y !== exp_q[0]) begin fails++; $display("FAIL rand_data c=%0d: got %h want %h", c, y, exp_q[0]); end
               void'(exp_q.pop_front());
            end
         end
      end
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
      tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL rand_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end
   endtask

   task automatic test_reset_mid();
      logic acc, rdy, ov; logic [15:0] y, x; logic [9:0] a; int lat;
      cycle(1'b1, 16'h8000, 1'b1, acc, rdy, ov, y);
      cycle(1'b1, 16'h0400, 1'b1, acc, rdy, ov, y);
      cycle(1'b1, 16'hFA00, 1'b1, acc, rdy, ov, y);
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_inflight: got %b want 1", out_valid); end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_sat = 0;
      exp_q.delete();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
      tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_sat_cnt: got %0d want 0", sat_cnt); end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cycle(1'b0, 16'h0, 1'b1, acc, rdy, ov, y);
         tests++; if (ov !== 1'b0) begin fails++; $display("FAIL rstmid_stale c=%0d: got %b want 0", c, ov); end
      end
      x = 16'($urandom);
      if (x == 16'h8000) x = 16'h1234;
      send_one(x, a, lat, y);
      tests++; if (y !== ref_y(x) || lat != 3) begin fails++; $display("FAIL rstmid_after x=%h: got %h lat %0d want %h lat 3", x, y, lat, ref_y(x)); end
   endtask

   initial begin
      rom[0] = 16'h4000;
      for (int i = 1; i <= 64; i++) rom[i] = 16'h40CC + ((16'h6BB1 - 16'h40CC) * (i - 1)) / 63;
      for (int t = 1; t <= 448; t++) rom[64 + t] = 16'h6BB1 + (16'h144F * (t * (896 - t))) / 200704;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = '0;
      test_reset();
      test_zero();
      test_one_sigma();
      test_interp();
      test_saturation();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
